display_timing_480p: RTL and testbench

- Video timing generator in the pixel clock domain, fed by the 33.75 MHz pixel clock and its lock flag from the clock generator.
- Produces screen coordinates, hsync, vsync, data enable and frame/line strobes for 848x480 at 60 Hz.
- Waits for a stable PLL lock before starting and drops back to idle if lock is lost.
- Sits between the clock generator and the pixel/drawing logic and the video output pins.

---
 rtl/display_timing_480p.sv | 147 ++++++++++++++
 tb/tb_display_timing_480p.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/display_timing_480p.sv
// Video timing generator for 848x480 at 60 Hz in the pixel clock domain.
// Waits for a stable PLL lock, then emits coordinates, syncs, data enable and strobes.
module display_timing_480p #(
  parameter int   CORDW    = 11,
  parameter int   H_ACTIVE = 848,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 112,
  parameter int   H_BP     = 112,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 6,
  parameter int   V_SYNC   = 8,
  parameter int   V_BP     = 23,
  parameter logic H_POL    = 1'b1,
  parameter logic V_POL    = 1'b1,
  parameter int   SETTLE   = 16
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             clk_locked,
  output logic             running,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame,
  output logic             line
);

  // state    | meaning
  // ST_IDLE  | no lock; outputs parked at idle values
  // ST_SETTLE| lock seen; counting consecutive locked cycles
  // ST_RUN   | lock stable; timing generated

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RUN} state_t;

  state_t           state, state_nxt;
  logic [15:0]      cnt, cnt_nxt;
  logic [CORDW-1:0] sx_nxt, sy_nxt;
  logic             run_nxt, hs_nxt, vs_nxt, de_nxt, frame_nxt, line_nxt;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      running <= 1'b0;
      sx      <= '0;
      sy      <= '0;
      hsync   <= ~H_POL;
      vsync   <= ~V_POL;
      de      <= 1'b0;
      frame   <= 1'b0;
      line    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      running <= run_nxt;
      sx      <= sx_nxt;
      sy      <= sy_nxt;
      hsync   <= hs_nxt;
      vsync   <= vs_nxt;
      de      <= de_nxt;
      frame   <= frame_nxt;
      line    <= line_nxt;
    end
  end

  // The IDLE cycle that first sees lock counts as the first settle cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (clk_locked) begin
          if (SETTLE == 1) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = 16'd1;
          end
        end
      end
      ST_SETTLE: begin
        if (!clk_locked) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
        if (!clk_locked) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Flags are computed from the next coordinates so they register alongside them.
  always_comb begin
    sx_nxt    = '0;
    sy_nxt    = '0;
    run_nxt   = (state_nxt == ST_RUN);
    hs_nxt    = ~H_POL;
    vs_nxt    = ~V_POL;
    de_nxt    = 1'b0;
    frame_nxt = 1'b0;
    line_nxt  = 1'b0;
    if (state == ST_RUN && state_nxt == ST_RUN) begin
      if (sx == H_LAST) begin
        sx_nxt = '0;
        sy_nxt = (sy == V_LAST) ? '0 : sy + 1'b1;
      end else begin
        sx_nxt = sx + 1'b1;
        sy_nxt = sy;
      end
    end
    if (run_nxt) begin
      hs_nxt    = (sx_nxt >= HS_START && sx_nxt <= HS_END) ? H_POL : ~H_POL;
      vs_nxt    = (sy_nxt >= VS_START && sy_nxt <= VS_END) ? V_POL : ~V_POL;
      de_nxt    = (sx_nxt < H_ACT) && (sy_nxt < V_ACT);
      frame_nxt = (sx_nxt == '0) && (sy_nxt == '0);
      line_nxt  = (sx_nxt == '0);
    end
  end

endmodule

// File: tb/tb_display_timing_480p.sv
// Directed bench: default 848x480 instance for lock/settle/line checks,
// plus a shrunken instance (16x9 total) so whole frames fit in a short run.
module tb_display_timing_480p;

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;
  logic locked0 = 1'b1;
  logic locked1 = 1'b1;

  logic        run0, hs0, vs0, de0, fr0, ln0;
  logic [10:0] sx0, sy0;
  logic        run1, hs1, vs1, de1, fr1, ln1;
  logic [10:0] sx1, sy1;

  int checks = 0;
  int failures = 0;

  always #5 clk_pix = ~clk_pix;

  display_timing_480p dut0 (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .clk_locked(locked0), .running(run0),
    .sx(sx0), .sy(sy0), .hsync(hs0), .vsync(vs0), .de(de0), .frame(fr0), .line(ln0)
  );

  // 8+2+3+3 = 16 columns, 4+1+2+2 = 9 rows, active-low hsync, settle of 3.
  display_timing_480p #(
    .CORDW(11), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b1), .SETTLE(3)
  ) dut1 (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .clk_locked(locked1), .running(run1),
    .sx(sx1), .sy(sy1), .hsync(hs1), .vsync(vs1), .de(de1), .frame(fr1), .line(ln1)
  );

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hc, dc, ex, ey, hc1, vc1, dc1, lc1, fc1, fpos;
    logic [5:0] exp_flags;

    // reset with lock present: idle values throughout
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_flags0", {26'd0, run0, hs0, vs0, de0, fr0, ln0}, 32'd0);
      chk("rst_xy0", {10'd0, sx0, sy0}, 32'd0);
      chk("rst_flags1", {26'd0, run1, hs1, vs1, de1, fr1, ln1}, 32'b010000);
    end

    rst_pix = 1'b0;
    locked0 = 1'b0;
    locked1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("unlocked_run", {31'd0, run0}, 32'd0);
    end

    // lock rises: running exactly 16 cycles later
    locked0 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("settle_run", {31'd0, run0}, (i == 16) ? 32'd1 : 32'd0);
    end
    chk("first_xy", {10'd0, sx0, sy0}, 32'd0);
    chk("first_flags", {26'd0, run0, hs0, vs0, de0, fr0, ln0}, 32'b100111);

    // walk line 0 of the default timing
    hc = int'(hs0);
    dc = int'(de0);
    for (int j = 1; j <= 1088; j++) begin
      tick();
      if (j < 1088) begin
        hc += int'(hs0);
        dc += int'(de0);
      end
      case (j)
        1:    chk("sx1_line", {31'd0, ln0}, 32'd0);
        847:  chk("de_847", {31'd0, de0}, 32'd1);
        848:  chk("de_848", {31'd0, de0}, 32'd0);
        863:  chk("hs_863", {31'd0, hs0}, 32'd0);
        864:  chk("hs_864", {31'd0, hs0}, 32'd1);
        975:  chk("hs_975", {31'd0, hs0}, 32'd1);
        976:  chk("hs_976", {31'd0, hs0}, 32'd0);
        1087: chk("sx_1087", {21'd0, sx0}, 32'd1087);
        1088: begin
          chk("wrap_xy", {10'd0, sx0, sy0}, {10'd0, 11'd0, 11'd1});
          chk("wrap_flags", {26'd0, run0, hs0, vs0, de0, fr0, ln0}, 32'b100101);
        end
        default: ;
      endcase
    end
    chk("hs_count_line", hc, 32'd112);
    chk("de_count_line", dc, 32'd848);

    // lock loss in RUN: next cycle idle
    locked0 = 1'b0;
    tick();
    chk("loss_flags0", {26'd0, run0, hs0, vs0, de0, fr0, ln0}, 32'd0);
    chk("loss_xy0", {10'd0, sx0, sy0}, 32'd0);

    // glitch at settle count 10
    locked0 = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_glitch_run", {31'd0, run0}, 32'd0);
    locked0 = 1'b0;
    tick();
    chk("glitch_run", {31'd0, run0}, 32'd0);
    locked0 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("resettle_run", {31'd0, run0}, (i == 16) ? 32'd1 : 32'd0);
    end
    chk("resettle_frame", {30'd0, fr0, ln0}, 32'b11);
    tick();
    tick();
    chk("run_sx2", {21'd0, sx0}, 32'd2);

    // reset mid-operation overrides lock
    rst_pix = 1'b1;
    tick();
    chk("midrst_flags0", {26'd0, run0, hs0, vs0, de0, fr0, ln0}, 32'd0);
    chk("midrst_xy0", {10'd0, sx0, sy0}, 32'd0);
    rst_pix = 1'b0;

    // small instance: settle of 3
    locked1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("s_settle_run", {31'd0, run1}, (i == 3) ? 32'd1 : 32'd0);
    end

    // hand model: hsync active-low at x 10..12, vsync y 5..6, de x<8 && y<4
    ex = 0; ey = 0;
    hc1 = 0; vc1 = 0; dc1 = 0; lc1 = 0; fc1 = 0; fpos = -1;
    for (int c = 0; c <= 197; c++) begin
      exp_flags = {1'b1,
                   !(ex >= 10 && ex <= 12),
                   (ey >= 5 && ey <= 6),
                   (ex < 8 && ey < 4),
                   (ex == 0 && ey == 0),
                   (ex == 0)};
      chk("s_xy", {10'd0, sx1, sy1}, {10'd0, 11'(ex), 11'(ey)});
      chk("s_flags", {26'd0, run1, hs1, vs1, de1, fr1, ln1}, {26'd0, exp_flags});
      if (c < 144) begin
        hc1 += int'(!hs1);
        vc1 += int'(vs1);
        dc1 += int'(de1);
        lc1 += int'(ln1);
        fc1 += int'(fr1);
      end else if (fr1 && fpos < 0) begin
        fpos = c;
      end
      if (c < 197) begin
        tick();
        if (ex == 15) begin
          ex = 0;
          ey = (ey == 8) ? 0 : ey + 1;
        end else begin
          ex = ex + 1;
        end
      end
    end
    chk("s_hs_count", hc1, 32'd27);
    chk("s_vs_count", vc1, 32'd32);
    chk("s_de_count", dc1, 32'd32);
    chk("s_line_count", lc1, 32'd9);
    chk("s_frame_count", fc1, 32'd1);
    chk("s_frame_period", fpos, 32'd144);

    // lock loss at x=5, y=3 of the second frame
    locked1 = 1'b0;
    tick();
    chk("s_loss_flags", {26'd0, run1, hs1, vs1, de1, fr1, ln1}, 32'b010000);
    chk("s_loss_xy", {10'd0, sx1, sy1}, 32'd0);
    locked1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("s_relock_run", {31'd0, run1}, (i == 3) ? 32'd1 : 32'd0);
    end
    chk("s_relock_xy", {10'd0, sx1, sy1}, 32'd0);
    chk("s_relock_flags", {26'd0, run1, hs1, vs1, de1, fr1, ln1}, 32'b110111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
